q_control: RTL and testbench

Closed-loop hill-climbing controller for the front-end Q loop, directly downstream of the instability detector. It steps the reference current `i_ref` within `[I_REF_MIN, i_ref_max]` and measures Q after each step through a start/ready handshake with the Q-measurement stage. It settles on the current that gives maximum Q and reports lock. `i_ref_max` is the instability detector's `i_ref_setup` output, which is the upper bound of the search.

---
 rtl/q_ctrl_pkg.sv | 18 +
 rtl/cycle_timer.sv | 32 +++
 rtl/q_control.sv | 210 +++++++++++++++++++++
 tb/tb_q_control.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/q_ctrl_pkg.sv
// q_ctrl_pkg: shared definitions for the Q-loop hill-climbing controller.
//   state_e : controller FSM states
//   UP / DN : search direction encodings
package q_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    REQ,
    WAIT,
    EVAL,
    LOCK
  } state_e;

  localparam logic UP = 1'b0;
  localparam logic DN = 1'b1;

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter with a done flag.
//   clk, rst      : clock, async active-low reset
//   load/load_val : load the counter (load has priority over counting)
//   done          : counter is at zero
// Loading N-1 on entry to a state and leaving when done makes the state
// last exactly N cycles.
module cycle_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/q_control.sv
// q_control: hill-climbing search of i_ref in [I_REF_MIN, i_ref_max] for
// maximum Q, measured through a start/ready handshake.
//   clk, rst              : clock, async active-low reset
//   enable                : run control, low returns to IDLE
//   i_ref_max             : search upper bound
//   meas_start/meas_ready : measurement request / done pulse
//   q_measured            : Q sample, valid with meas_ready
//   i_ref, i_ref_best     : applied current, current at best Q
//   q_best, locked        : best Q so far, search converged
//   meas_err              : sticky measurement-timeout flag
module q_control
  import q_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH     = 10,
  parameter int I_REF_MIN     = 0,
  parameter int I_REF_STEP    = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int MEAS_TIMEOUT  = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] i_ref_max,
  output logic                 meas_start,
  input  logic                 meas_ready,
  input  logic [BUS_WIDTH-1:0] q_measured,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic [BUS_WIDTH-1:0] i_ref_best,
  output logic [BUS_WIDTH-1:0] q_best,
  output logic                 locked,
  output logic                 meas_err
);

  localparam int W  = BUS_WIDTH;
  localparam int W1 = BUS_WIDTH + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(MEAS_TIMEOUT + 1);
  localparam logic [W-1:0]  MIN_V     = W'(I_REF_MIN);
  localparam logic [W:0]    STEP_V    = W1'(I_REF_STEP);
  localparam logic [W:0]    DN_LIM    = W1'(I_REF_MIN + I_REF_STEP);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LD   = TW'(MEAS_TIMEOUT - 1);

  state_e       state_q, state_d;
  logic         dir_q, dir_d, dir_n;
  logic [1:0]   fail_q, fail_d, fail_n;
  logic [W-1:0] sample_q, sample_d;
  logic         sample_vld_q, sample_vld_d;
  logic [W-1:0] i_ref_q, i_ref_d, i_ref_best_q, i_ref_best_d;
  logic [W-1:0] q_best_q, q_best_d, base, nxt;
  logic         meas_start_q, meas_start_d, locked_q, locked_d;
  logic         meas_err_q, meas_err_d;
  logic         settle_ld, wait_ld, settle_done, wait_done;

  cycle_timer #(.CW(SW)) u_settle_tmr (
    .clk(clk), .rst(rst), .load(settle_ld), .load_val(SETTLE_LD), .done(settle_done)
  );

  cycle_timer #(.CW(TW)) u_wait_tmr (
    .clk(clk), .rst(rst), .load(wait_ld), .load_val(WAIT_LD), .done(wait_done)
  );

  // One saturating step; UP in W+1 bits so base+STEP cannot wrap.
  function automatic logic [W-1:0] step_f(input logic [W-1:0] b, input logic d,
                                          input logic [W-1:0] lim);
    logic [W:0] sum;
    sum = {1'b0, b} + STEP_V;
    if (d == UP) step_f = (sum > {1'b0, lim}) ? lim : sum[W-1:0];
    else         step_f = ({1'b0, b} < DN_LIM) ? MIN_V : (b - STEP_V[W-1:0]);
  endfunction

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    fail_d       = fail_q;
    sample_d     = sample_q;
    sample_vld_d = sample_vld_q;
    i_ref_d      = i_ref_q;
    i_ref_best_d = i_ref_best_q;
    q_best_d     = q_best_q;
    meas_start_d = 1'b0;
    locked_d     = locked_q;
    meas_err_d   = meas_err_q;
    settle_ld    = 1'b0;
    wait_ld      = 1'b0;
    fail_n       = fail_q;
    dir_n        = dir_q;
    base         = i_ref_q;
    nxt          = i_ref_q;

    if (!enable) begin
      // Abort: any outstanding measurement is dropped with the state.
      state_d  = IDLE;
      i_ref_d  = MIN_V;
      locked_d = 1'b0;
    end else if (state_q != IDLE && i_ref_max < i_ref_q) begin
      // Bound fell below the applied current: clamp and search downward.
      i_ref_d      = i_ref_max;
      i_ref_best_d = (i_ref_best_q > i_ref_max) ? i_ref_max : i_ref_best_q;
      q_best_d     = '0;
      locked_d     = 1'b0;
      fail_d       = '0;
      dir_d        = DN;
      state_d      = SETTLE;
      settle_ld    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = SETTLE;
          settle_ld    = 1'b1;
          q_best_d     = '0;
          locked_d     = 1'b0;
          dir_d        = UP;
          fail_d       = '0;
          i_ref_d      = MIN_V;
          i_ref_best_d = MIN_V;
        end
        SETTLE: if (settle_done) begin
          state_d      = REQ;
          meas_start_d = 1'b1;
        end
        REQ: begin
          state_d = WAIT;
          wait_ld = 1'b1;
        end
        WAIT: begin
          if (meas_ready) begin
            sample_d     = q_measured;
            sample_vld_d = 1'b1;
            state_d      = EVAL;
          end else if (wait_done) begin
            sample_vld_d = 1'b0;
            meas_err_d   = 1'b1;
            state_d      = EVAL;
          end
        end
        EVAL: begin
          if (sample_vld_q && sample_q > q_best_q) begin
            q_best_d     = sample_q;
            i_ref_best_d = i_ref_q;
            fail_n       = '0;
          end else begin
            fail_n = fail_q + 2'd1;
            base   = i_ref_best_q;
            dir_n  = ~dir_q;
          end
          nxt = step_f(base, dir_n, i_ref_max);
          // Blocked at a bound: count a failure and try the other way.
          if (fail_n < 2'd2 && nxt == base) begin
            fail_n = fail_n + 2'd1;
            dir_n  = ~dir_n;
            nxt    = step_f(base, dir_n, i_ref_max);
          end
          dir_d  = dir_n;
          fail_d = fail_n;
          if (fail_n >= 2'd2 || nxt == base) begin
            state_d  = LOCK;
            i_ref_d  = i_ref_best_d;
            locked_d = 1'b1;
          end else begin
            state_d   = SETTLE;
            settle_ld = 1'b1;
            i_ref_d   = nxt;
          end
        end
        LOCK: begin
          i_ref_d  = i_ref_best_q;
          locked_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dir_q        <= UP;
      fail_q       <= '0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      i_ref_q      <= MIN_V;
      i_ref_best_q <= MIN_V;
      q_best_q     <= '0;
      meas_start_q <= 1'b0;
      locked_q     <= 1'b0;
      meas_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      fail_q       <= fail_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      i_ref_q      <= i_ref_d;
      i_ref_best_q <= i_ref_best_d;
      q_best_q     <= q_best_d;
      meas_start_q <= meas_start_d;
      locked_q     <= locked_d;
      meas_err_q   <= meas_err_d;
    end
  end

  assign meas_start = meas_start_q;
  assign i_ref      = i_ref_q;
  assign i_ref_best = i_ref_best_q;
  assign q_best     = q_best_q;
  assign locked     = locked_q;
  assign meas_err   = meas_err_q;

endmodule

// File: tb/tb_q_control.sv
// tb_q_control: bench for q_control. A transaction-level search model gives
// the sequence of currents that must be measured and the final lock point;
// a compare process checks every meas_start against it.
module tb_q_control;

  localparam int W        = 10;
  localparam int STEP     = 10;
  localparam int RESP_LAT = 3;

  logic         clk = 1'b0;
  logic         rst, enable, meas_ready, meas_start, locked, meas_err;
  logic [W-1:0] i_ref_max, q_measured, i_ref, i_ref_best, q_best;

  always #5 clk = ~clk;

  q_control dut (
    .clk(clk), .rst(rst), .enable(enable), .i_ref_max(i_ref_max),
    .meas_start(meas_start), .meas_ready(meas_ready), .q_measured(q_measured),
    .i_ref(i_ref), .i_ref_best(i_ref_best), .q_best(q_best),
    .locked(locked), .meas_err(meas_err)
  );

  int  ntests = 0, nfail = 0;
  int  qmode = 0, to_idx = -1, meas_n = 0, cyc = 0;
  bit  resp_on = 1'b0, chk_on = 1'b0, prev_ms = 1'b0;
  int  expq[$], ms_cyc[$];
  int  exp_best, exp_qb, exp_npts;

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Plant Q response as a function of the applied current.
  function automatic int qf(input int i);
    case (qmode)
      0:       qf = 200 - ((i > 120) ? i - 120 : 120 - i);
      1:       qf = i / 2 + 1;
      default: qf = 300 - ((i > 200) ? i - 200 : 200 - i);
    endcase
  endfunction

  function automatic int clip_step(input int cur, input int dir, input int mx);
    if (dir > 0) clip_step = (cur + STEP > mx) ? mx : cur + STEP;
    else         clip_step = (cur < STEP) ? 0 : cur - STEP;
  endfunction

  // Hill climb over integers: list of measured points, final best/Q.
  function automatic void model_run(input int start, input int dir0, input int mx);
    int cur, dir, fail, q, nxt;
    cur = start; dir = dir0; fail = 0;
    exp_best = start; exp_qb = 0;
    expq.delete();
    for (int n = 0; n < 200; n++) begin
      expq.push_back(cur);
      q = (n == to_idx) ? -1 : qf(cur);
      if (q > exp_qb) begin exp_qb = q; exp_best = cur; fail = 0; end
      else begin fail++; cur = exp_best; dir = -dir; end
      if (fail >= 2) break;
      nxt = clip_step(cur, dir, mx);
      if (nxt == cur) begin
        fail++; dir = -dir;
        if (fail >= 2) break;
        nxt = clip_step(cur, dir, mx);
        if (nxt == cur) break;
      end
      cur = nxt;
    end
    exp_npts = expq.size();
  endfunction

  // Q-measurement stage responder.
  initial begin
    int ii, n;
    forever begin
      @(negedge clk);
      if (resp_on && meas_start) begin
        ii = int'(i_ref); n = meas_n; meas_n++;
        repeat (RESP_LAT) @(negedge clk);
        if (n != to_idx && resp_on) begin
          meas_ready = 1'b1; q_measured = W'(qf(ii));
          @(negedge clk);
          meas_ready = 1'b0;
        end
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    cyc++;
    if (meas_start) ms_cyc.push_back(cyc);
    if (chk_on) begin
      chk("meas_start_single", int'(prev_ms && meas_start), 0);
      if (meas_start) begin
        if (expq.size() == 0) chk("meas_start_unexpected", int'(meas_start), 0);
        else                  chk("meas_iref", int'(i_ref), expq.pop_front());
      end
      if (locked) chk("locked_iref_eq_best", int'(i_ref), int'(i_ref_best));
    end
    prev_ms = meas_start;
  end

  task automatic start_run(input int mode, input int mx, input int toi);
    chk_on = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    qmode = mode; i_ref_max = W'(mx); to_idx = toi; meas_n = 0; resp_on = 1'b1;
    ms_cyc.delete();
    model_run(0, 1, mx);
    chk_on = 1'b1; enable = 1'b1;
  endtask

  task automatic wait_lock(input string nm);
    int c = 0;
    while (!locked && c < 4000) begin @(negedge clk); c++; end
    chk({nm, "_lock_reached"}, int'(locked), 1);
  endtask

  task automatic check_final(input string nm);
    chk({nm, "_iref"},      int'(i_ref),      exp_best);
    chk({nm, "_iref_best"}, int'(i_ref_best), exp_best);
    chk({nm, "_q_best"},    int'(q_best),     exp_qb);
    chk({nm, "_pts_left"},  expq.size(),      0);
  endtask

  initial begin
    int c;
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b0; enable = 1'b0; i_ref_max = W'(300); meas_ready = 1'b0; q_measured = '0;
    #7;
    chk("rst_iref", int'(i_ref), 0);
    chk("rst_iref_best", int'(i_ref_best), 0);
    chk("rst_q_best", int'(q_best), 0);
    chk("rst_meas_start", int'(meas_start), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_meas_err", int'(meas_err), 0);
    @(negedge clk); rst = 1'b1;

    // Basic climb, peak at 120.
    start_run(0, 300, -1);
    chk("t1_model_npts", exp_npts, 15);
    c = 0;
    do begin @(negedge clk); c++; end while (!meas_start && c < 100);
    chk("t1_first_req_latency", c, 17);
    wait_lock("t1");
    check_final("t1");
    chk("t1_iref_lit", int'(i_ref), 120);
    chk("t1_q_best_lit", int'(q_best), 200);
    chk("t1_iter_latency", (ms_cyc.size() > 1) ? ms_cyc[1] - ms_cyc[0] : 0, 21);

    // Upper bound saturation at 95.
    start_run(1, 95, -1);
    chk("t2_model_npts", exp_npts, 12);
    wait_lock("t2");
    check_final("t2");
    chk("t2_iref_lit", int'(i_ref), 95);

    // Third measurement never answered.
    start_run(0, 300, 2);
    chk("t3_err_before", int'(meas_err), 0);
    wait_lock("t3");
    check_final("t3");
    chk("t3_meas_err", int'(meas_err), 1);
    chk("t3_iref_lit", int'(i_ref), 10);
    chk("t3_nreq", ms_cyc.size(), 4);
    chk("t3_timeout_to_eval", (ms_cyc.size() > 3) ? ms_cyc[3] - ms_cyc[2] : 0, 1023 + 1 + 1 + 16);

    // Clamp from a lock at 200.
    start_run(2, 300, -1);
    chk("t4_model_npts", exp_npts, 23);
    wait_lock("t4");
    check_final("t4");
    chk("t4_iref_lit", int'(i_ref), 200);
    i_ref_max = W'(150);
    model_run(150, -1, 150);
    @(negedge clk);
    chk("t4_clamp_iref", int'(i_ref), 150);
    chk("t4_clamp_iref_best", int'(i_ref_best), 150);
    chk("t4_clamp_locked", int'(locked), 0);
    chk("t4_clamp_q_best", int'(q_best), 0);
    wait_lock("t4b");
    check_final("t4b");
    chk("t4b_q_best_lit", int'(q_best), 250);

    // Abort in WAIT with a late meas_ready.
    start_run(0, 300, 3);
    c = 0;
    while (meas_n < 4 && c < 2000) begin @(negedge clk); c++; end
    chk("t5_reached_wait", meas_n, 4);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    meas_ready = 1'b1; q_measured = W'(999);
    @(negedge clk);
    meas_ready = 1'b0;
    chk("t5_iref", int'(i_ref), 0);
    chk("t5_q_best", int'(q_best), 100);
    chk("t5_iref_best", int'(i_ref_best), 20);
    chk("t5_locked", int'(locked), 0);
    expq.delete();
    repeat (40) @(negedge clk);

    // Async reset mid-SETTLE.
    start_run(0, 300, -1);
    c = 0;
    while (ms_cyc.size() < 3 && c < 2000) begin @(negedge clk); c++; end
    repeat (8) @(negedge clk);
    chk("t6_pre_iref", int'(i_ref), 30);
    chk_on = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t6_iref", int'(i_ref), 0);
    chk("t6_iref_best", int'(i_ref_best), 0);
    chk("t6_q_best", int'(q_best), 0);
    chk("t6_meas_start", int'(meas_start), 0);
    chk("t6_locked", int'(locked), 0);
    chk("t6_meas_err", int'(meas_err), 0);
    @(negedge clk);
    resp_on = 1'b0; enable = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
